// File: rtl/mem_bus_arbiter.sv
// Shares one RAM between instruction fetch and MEM-stage data accesses.
// Data has priority; a starve counter forces an inst grant after a run of data grants.
module mem_bus_arbiter #(
    parameter int unsigned RAM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ack,
    output logic        inst_err,
    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        stall_req
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT  = 3'(RAM_LATENCY);
    localparam logic [2:0] SLIM = 3'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  starve_q, starve_d;
    logic        gnt_data_q, gnt_data_d;
    logic        err_q, err_d;
    logic [3:0]  we_q, we_d;
    logic        ram_en_q, ram_en_d;
    logic [3:0]  ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        inst_ack_q, inst_ack_d;
    logic        data_ack_q, data_ack_d;
    logic        inst_err_q, inst_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        gnt_data_d   = gnt_data_q;
        err_d        = err_q;
        we_d         = we_q;
        ram_en_d     = 1'b0;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        inst_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    gnt_data_d = data_req && !(inst_req && starve_q == SLIM);
                    if (gnt_data_d) begin
                        if (!inst_req)
                            starve_d = 3'd0;
                        else if (starve_q != SLIM)
                            starve_d = starve_q + 3'd1;
                        we_d        = data_we;
                        ram_addr_d  = data_addr;
                        ram_wdata_d = data_wdata;
                        err_d       = 1'b0;
                    end else begin
                        starve_d    = 3'd0;
                        we_d        = 4'b0000;
                        ram_addr_d  = inst_addr;
                        ram_wdata_d = 32'h0;
                        err_d       = inst_addr[1:0] != 2'b00;
                    end
                    // Misaligned fetch never touches the RAM
                    if (err_d) begin
                        state_d      = DONE;
                        inst_ack_d   = 1'b1;
                        inst_err_d   = 1'b1;
                        inst_rdata_d = 32'h0;
                    end else begin
                        state_d  = ISSUE;
                        ram_en_d = 1'b1;
                        ram_we_d = we_d;
                    end
                end
            end
            ISSUE: begin
                cnt_d    = 3'd1;
                ram_we_d = 4'b0000;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_q == LAT) begin
                    state_d = DONE;
                    if (gnt_data_q) begin
                        data_ack_d = 1'b1;
                        if (we_q == 4'b0000)
                            data_rdata_d = ram_rdata;
                    end else begin
                        inst_ack_d   = 1'b1;
                        inst_rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            starve_q     <= 3'd0;
            gnt_data_q   <= 1'b0;
            err_q        <= 1'b0;
            we_q         <= 4'b0000;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 4'b0000;
            ram_addr_q   <= 32'h0;
            ram_wdata_q  <= 32'h0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            inst_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            gnt_data_q   <= gnt_data_d;
            err_q        <= err_d;
            we_q         <= we_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            inst_err_q   <= inst_err_d;
        end
    end

    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_ack   = inst_ack_q;
    assign data_ack   = data_ack_q;
    assign inst_err   = inst_err_q;
    assign stall_req  = (inst_req && !inst_ack_q) || (data_req && !data_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_bus_arbiter;

    localparam int L  = 2;
    localparam int SL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic [31:0] inst_rdata;
    logic        inst_ack;
    logic        inst_err;
    logic        data_req = 1'b0;
    logic [3:0]  data_we = 4'h0;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        stall_req;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.RAM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_ack(inst_ack), .inst_err(inst_err),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .stall_req(stall_req)
    );

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // Reference model: one transaction described by its absolute cycle numbers
    bit          m_ok = 0, m_busy = 0, m_gd = 0, m_err = 0;
    int          m_tiss = 0, m_tdone = 0, m_starve = 0;
    logic [3:0]  m_we = 4'h0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_ird = 32'h0, m_drd = 32'h0;

    always @(negedge clk) begin
        bit en_e, ia_e, da_e;
        #2;
        en_e = m_busy && !m_err && cyc == m_tiss;
        ia_e = m_busy && !m_gd && cyc == m_tdone;
        da_e = m_busy && m_gd && cyc == m_tdone;
        if (m_ok) begin
            chk("ram_en", ram_en, en_e);
            chk("ram_we", ram_we, en_e ? m_we : 4'h0);
            if (en_e) begin
                chk("ram_addr", ram_addr, m_addr);
                chk("ram_wdata", ram_wdata, m_wdata);
            end
            chk("inst_ack", inst_ack, ia_e);
            chk("data_ack", data_ack, da_e);
            chk("inst_err", inst_err, ia_e && m_err);
            chk("inst_rdata", inst_rdata, m_ird);
            chk("data_rdata", data_rdata, m_drd);
            chk("stall_req", stall_req, (inst_req && !ia_e) || (data_req && !da_e));
        end
        if (!rst) begin
            m_ok = 1; m_busy = 0; m_starve = 0; m_ird = 0; m_drd = 0;
        end else if (m_busy) begin
            if (!m_err && m_we == 4'h0 && cyc == m_tiss + L) begin
                if (m_gd) m_drd = ram_rdata;
                else      m_ird = ram_rdata;
            end
            if (cyc == m_tdone) m_busy = 0;
        end else if (inst_req || data_req) begin
            m_gd = data_req && !(inst_req && m_starve >= SL);
            if (m_gd && inst_req) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            else m_starve = 0;
            m_err   = !m_gd && inst_addr[1:0] != 2'b00;
            m_we    = m_gd ? data_we : 4'h0;
            m_addr  = m_gd ? data_addr : inst_addr;
            m_wdata = m_gd ? data_wdata : 32'h0;
            m_tiss  = cyc + 1;
            m_tdone = m_err ? cyc + 1 : cyc + 2 + L;
            if (m_err) m_ird = 32'h0;
            m_busy = 1;
        end
        cyc++;
    end

    task automatic nxt();
        @(negedge clk);
        ram_rdata = $urandom;
    endtask

    task automatic wait_ack(input bit is_data);
        int n;
        n = 0;
        forever begin
            nxt(); #3; n++;
            if (is_data ? data_ack : inst_ack) break;
            if (n > 50) begin
                vecs++; errs++;
                $display("FAIL ack_timeout: got no ack after %0d cycles, required within 50", n);
                break;
            end
        end
    endtask

    task automatic new_data();
        data_req   = 1'b1;
        data_addr  = $urandom & 32'hFFFF_FFFC;
        data_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
        data_wdata = $urandom;
    endtask

    task automatic new_inst();
        inst_req  = 1'b1;
        inst_addr = $urandom;
        if ($urandom_range(0, 3) != 0) inst_addr[1:0] = 2'b00;
    endtask

    initial begin
        string order;
        int    n_inst, n;
        inst_req = 1; data_req = 1; inst_addr = 32'h40; data_addr = 32'h80;
        repeat (3) nxt();
        #3;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        chk("rst_acks", {inst_ack, data_ack, inst_err}, 0);
        nxt(); rst = 1;
        nxt(); #3;
        chk("first_grant_en", ram_en, 1);
        chk("first_grant_data", ram_addr, 32'h80);
        wait_ack(1); data_req = 0;
        wait_ack(0); inst_req = 0;
        nxt(); nxt();

        // Single read at 0x100
        nxt(); data_req = 1; data_addr = 32'h100; data_we = 0; #3;
        chk("rd_stall_c0", stall_req, 1);
        nxt(); #3;
        chk("rd_en_c1", ram_en, 1);
        chk("rd_addr_c1", ram_addr, 32'h100);
        chk("rd_stall_c1", stall_req, 1);
        nxt(); #3;
        chk("rd_en_c2", ram_en, 0);
        chk("rd_stall_c2", stall_req, 1);
        nxt(); ram_rdata = 32'hDEADBEEF; #3;
        chk("rd_ack_c3", data_ack, 0);
        chk("rd_stall_c3", stall_req, 1);
        nxt(); #3;
        chk("rd_ack_c4", data_ack, 1);
        chk("rd_data_c4", data_rdata, 32'hDEADBEEF);
        chk("rd_stall_c4", stall_req, 0);
        data_req = 0;

        // Byte write to 0x204
        nxt(); data_req = 1; data_we = 4'b0100; data_wdata = 32'h00AB0000; data_addr = 32'h204;
        nxt(); #3;
        chk("wr_en_c1", ram_en, 1);
        chk("wr_we_c1", ram_we, 4'b0100);
        chk("wr_addr_c1", ram_addr, 32'h204);
        chk("wr_wdata_c1", ram_wdata, 32'h00AB0000);
        nxt(); #3;
        chk("wr_en_c2", ram_en, 0);
        chk("wr_we_c2", ram_we, 0);
        nxt(); #3;
        chk("wr_ack_c3", data_ack, 0);
        nxt(); #3;
        chk("wr_ack_c4", data_ack, 1);
        chk("wr_rdata_kept", data_rdata, 32'hDEADBEEF);
        data_req = 0; data_we = 0;

        // Misaligned fetch
        nxt(); inst_req = 1; inst_addr = 32'h1002;
        nxt(); #3;
        chk("mis_ack", inst_ack, 1);
        chk("mis_err", inst_err, 1);
        chk("mis_rdata", inst_rdata, 0);
        chk("mis_no_en", ram_en, 0);
        inst_req = 0;
        nxt();

        // Contention: both ports always requesting
        order = ""; n_inst = 0;
        nxt(); inst_req = 1; data_req = 1; inst_addr = 32'h3000; data_addr = 32'h4000;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            forever begin
                #3; n++;
                if (data_ack) begin order = {order, "D"}; data_addr += 4; break; end
                if (inst_ack) begin order = {order, "I"}; inst_addr += 4; n_inst++; break; end
                if (n > 50) begin
                    vecs++; errs++;
                    $display("FAIL contend_timeout: got no ack after %0d cycles, required within 50", n);
                    break;
                end
                nxt();
            end
            nxt();
        end
        vecs++;
        if (order != "DDDIDDDI") begin
            errs++;
            $display("FAIL grant_order: got %s expected DDDIDDDI", order);
        end
        chk("inst_ack_count", n_inst, 2);
        inst_req = 0; data_req = 0;
        nxt(); nxt(); nxt(); nxt(); nxt(); nxt(); nxt(); nxt();

        // Reset during WAIT
        nxt(); data_req = 1; data_we = 0; data_addr = 32'h500;
        nxt(); #3; chk("rw_en_c1", ram_en, 1);
        nxt(); rst = 0;
        nxt(); rst = 1; #3;
        chk("rw_ack_c3", data_ack, 0);
        chk("rw_en_c3", ram_en, 0);
        chk("rw_rdata_clr", data_rdata, 0);
        nxt(); #3; chk("rw_reissue_c4", ram_en, 1);
        nxt(); #3; chk("rw_ack_c5", data_ack, 0);
        nxt(); #3; chk("rw_ack_c6", data_ack, 0);
        nxt(); #3; chk("rw_ack_c7", data_ack, 1);
        data_req = 0;
        nxt();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst = ($urandom_range(0, 299) != 0);
            if (data_req) begin
                if (data_ack) begin
                    if ($urandom_range(0, 1) != 0) new_data();
                    else data_req = 0;
                end else if ($urandom_range(0, 99) == 0) begin
                    data_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_data();
            end
            if (inst_req) begin
                if (inst_ack) begin
                    if ($urandom_range(0, 1) != 0) new_inst();
                    else inst_req = 0;
                end else if ($urandom_range(0, 99) == 0) begin
                    inst_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_inst();
            end
        end
        nxt(); nxt();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
